// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the pipelined ALU.
//   alu_op_e   : 3-bit opcode; all eight encodings are defined.
//   FLG_*      : bit positions inside the 4-bit flags vector {V, C, N, Z}.
//   pack_flags : assembles the flags vector from its individual bits.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_SHL   = 3'd5,
        ALU_SHR   = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_e;

    localparam int FLG_Z   = 0;
    localparam int FLG_N   = 1;
    localparam int FLG_C   = 2;
    localparam int FLG_V   = 3;
    localparam int FLAGS_W = 4;

    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic v,
        input logic c,
        input logic n,
        input logic z
    );
        logic [FLAGS_W-1:0] f;
        f        = 4'b0000;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Purely combinational ALU core: computes result and status flags for one
// operand/opcode bundle. Arithmetic is unsigned modulo 2^N.
// Ports:
//   operand1  [N-1:0] in  : operand A
//   operand2  [N-1:0] in  : operand B; low clog2(N) bits are the shift amount
//   operation alu_op_e in : opcode
//   result    [N-1:0] out : ALU result
//   flags     [3:0]   out : {overflow, carry, negative, zero}
// -----------------------------------------------------------------------------
module alu_exec
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         operand1,
    input  logic [N-1:0]         operand2,
    input  alu_op_e              operation,
    output logic [N-1:0]         result,
    output logic [FLAGS_W-1:0]   flags
);

    localparam int SHW = (N > 1) ? $clog2(N) : 1;

    logic [N:0]     sum_s;
    logic [N:0]     dif_s;
    logic [SHW-1:0] shamt_s;
    logic [N-1:0]   res_s;
    logic           carry_s;
    logic           ovf_s;

    // Subtraction as A + ~B + 1 so bit N is the "no borrow" carry.
    assign sum_s   = {1'b0, operand1} + {1'b0, operand2};
    assign dif_s   = {1'b0, operand1} + {1'b0, ~operand2} + {{N{1'b0}}, 1'b1};
    assign shamt_s = operand2[SHW-1:0];

    // Opcode decode: result, carry and signed overflow.
    always_comb begin
        res_s   = {N{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (operation)
            ALU_ADD: begin
                res_s   = sum_s[N-1:0];
                carry_s = sum_s[N];
                ovf_s   = (operand1[N-1] == operand2[N-1]) && (sum_s[N-1] != operand1[N-1]);
            end
            ALU_SUB: begin
                res_s   = dif_s[N-1:0];
                carry_s = dif_s[N];
                ovf_s   = (operand1[N-1] != operand2[N-1]) && (dif_s[N-1] != operand1[N-1]);
            end
            ALU_AND:   res_s = operand1 & operand2;
            ALU_OR:    res_s = operand1 | operand2;
            ALU_XOR:   res_s = operand1 ^ operand2;
            ALU_SHL:   res_s = operand1 << shamt_s;
            ALU_SHR:   res_s = operand1 >> shamt_s;
            ALU_PASSB: res_s = operand2;
            default:   res_s = {N{1'b0}};
        endcase
    end

    assign result = res_s;
    assign flags  = pack_flags(ovf_s, carry_s, res_s[N-1], (res_s == {N{1'b0}}));

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Pipelined N-bit ALU with valid/ready handshakes on both sides. The compute
// is done combinationally ahead of stage 1; stages 2..STAGES only carry the
// {result, flags} bundle. Each stage is a handshake register so the pipe runs
// at one bundle per cycle and absorbs full backpressure without bubbles.
// Ports:
//   clk       in  : rising-edge clock
//   reset_n   in  : asynchronous active-low reset, drops all in-flight bundles
//   in_valid  in  : operand/op bundle valid
//   in_ready  out : pipe can accept the bundle this cycle (combinational)
//   operand1  in  : operand A [N-1:0]
//   operand2  in  : operand B [N-1:0]
//   operation in  : opcode (alu_op_e)
//   out_valid out : result bundle valid (registered)
//   out_ready in  : consumer accepts the bundle this cycle
//   result    out : ALU result [N-1:0] (registered)
//   flags     out : {overflow, carry, negative, zero} (registered)
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         operand1,
    input  logic [N-1:0]         operand2,
    input  alu_op_e              operation,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         result,
    output logic [FLAGS_W-1:0]   flags
);

    logic [N-1:0]       exec_result_s;
    logic [FLAGS_W-1:0] exec_flags_s;

    logic [STAGES-1:0]  stage_valid_s;
    logic [N-1:0]       stage_result_s [STAGES];
    logic [FLAGS_W-1:0] stage_flags_s  [STAGES];

    // ready_s[k] is the load enable of stage k; the extra top entry is the consumer.
    logic [STAGES:0]    ready_s;

    alu_exec #(
        .N(N)
    ) u_exec (
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .result    (exec_result_s),
        .flags     (exec_flags_s)
    );

    assign ready_s[STAGES] = out_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic               up_valid_s;
            logic [N-1:0]       up_result_s;
            logic [FLAGS_W-1:0] up_flags_s;
            logic               valid_r;
            logic [N-1:0]       result_r;
            logic [FLAGS_W-1:0] flags_r;

            if (k == 0) begin : g_head
                assign up_valid_s  = in_valid;
                assign up_result_s = exec_result_s;
                assign up_flags_s  = exec_flags_s;
            end else begin : g_body
                assign up_valid_s  = stage_valid_s[k-1];
                assign up_result_s = stage_result_s[k-1];
                assign up_flags_s  = stage_flags_s[k-1];
            end

            // An empty stage can always load; a full one only if it drains this cycle.
            assign ready_s[k] = !valid_r || ready_s[k+1];

            // Handshake register: valid follows upstream on enable, data only when upstream is valid.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_r  <= 1'b0;
                    result_r <= {N{1'b0}};
                    flags_r  <= 4'b0000;
                end else if (ready_s[k]) begin
                    valid_r <= up_valid_s;
                    if (up_valid_s) begin
                        result_r <= up_result_s;
                        flags_r  <= up_flags_s;
                    end
                end
            end

            assign stage_valid_s[k]  = valid_r;
            assign stage_result_s[k] = result_r;
            assign stage_flags_s[k]  = flags_r;
        end
    endgenerate

    assign in_ready  = ready_s[0];
    assign out_valid = stage_valid_s[STAGES-1];
    assign result    = stage_result_s[STAGES-1];
    assign flags     = stage_flags_s[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Directed self-checking bench. Two instances share all inputs: u_dut2 with
// STAGES=2 (reset, streaming, opcode/flag vectors, mid-flight reset) and
// u_dut3 with STAGES=3 (backpressure and bubble-free refill).
// -----------------------------------------------------------------------------
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    alu_op_e     operation;

    logic        in_ready2, out_valid2;
    logic [7:0]  result2;
    logic [3:0]  flags2;
    logic        in_ready3, out_valid3;
    logic [7:0]  result3;
    logic [3:0]  flags3;

    int checks;
    int errors;

    alu_op_e     vop [12];
    logic [7:0]  va  [12];
    logic [7:0]  vb  [12];
    logic [7:0]  vr  [12];
    logic [3:0]  vf  [12];

    alu_pipe #(.N(8), .STAGES(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .operand1(operand1), .operand2(operand2), .operation(operation),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .flags(flags2)
    );

    alu_pipe #(.N(8), .STAGES(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready3),
        .operand1(operand1), .operand2(operand2), .operation(operation),
        .out_valid(out_valid3), .out_ready(out_ready), .result(result3), .flags(flags3)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
        operation = op;
        operand1  = a;
        operand2  = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus and checks.
    initial begin
        int  idx;
        int  outcnt;
        bit  acc;
        logic [7:0] a_v;
        logic [7:0] e_v;

        checks = 0;
        errors = 0;

        vop[0]  = ALU_ADD;   va[0]  = 8'hFF; vb[0]  = 8'h01; vr[0]  = 8'h00; vf[0]  = 4'b0101;
        vop[1]  = ALU_SUB;   va[1]  = 8'h05; vb[1]  = 8'h05; vr[1]  = 8'h00; vf[1]  = 4'b0101;
        vop[2]  = ALU_SHL;   va[2]  = 8'h81; vb[2]  = 8'hF9; vr[2]  = 8'h02; vf[2]  = 4'b0000;
        vop[3]  = ALU_SHR;   va[3]  = 8'h80; vb[3]  = 8'h03; vr[3]  = 8'h10; vf[3]  = 4'b0000;
        vop[4]  = ALU_SHL;   va[4]  = 8'hC5; vb[4]  = 8'h08; vr[4]  = 8'hC5; vf[4]  = 4'b0010;
        vop[5]  = ALU_SHR;   va[5]  = 8'h3C; vb[5]  = 8'h00; vr[5]  = 8'h3C; vf[5]  = 4'b0000;
        vop[6]  = ALU_SUB;   va[6]  = 8'h80; vb[6]  = 8'h01; vr[6]  = 8'h7F; vf[6]  = 4'b1100;
        vop[7]  = ALU_ADD;   va[7]  = 8'h80; vb[7]  = 8'h80; vr[7]  = 8'h00; vf[7]  = 4'b1101;
        vop[8]  = ALU_XOR;   va[8]  = 8'hA5; vb[8]  = 8'hFF; vr[8]  = 8'h5A; vf[8]  = 4'b0000;
        vop[9]  = ALU_OR;    va[9]  = 8'h00; vb[9]  = 8'h00; vr[9]  = 8'h00; vf[9]  = 4'b0001;
        vop[10] = ALU_PASSB; va[10] = 8'h11; vb[10] = 8'h9C; vr[10] = 8'h9C; vf[10] = 4'b0010;
        vop[11] = ALU_AND;   va[11] = 8'h0F; vb[11] = 8'hF0; vr[11] = 8'h00; vf[11] = 4'b0001;

        // Reset held with in_valid asserted.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(ALU_ADD, 8'h01, 8'h02);
        repeat (3) tick();
        check_eq("rst_out_valid2", out_valid2, 1'b0);
        check_eq("rst_result2",    result2,    8'h00);
        check_eq("rst_flags2",     flags2,     4'b0000);
        check_eq("rst_out_valid3", out_valid3, 1'b0);

        reset_n = 1'b1;
        #1;
        check_eq("rel_in_ready2", in_ready2, 1'b1);
        check_eq("rel_in_ready3", in_ready3, 1'b1);
        tick();                         // bundle accepted at this edge
        in_valid = 1'b0;
        check_eq("lat_cyc1_valid2", out_valid2, 1'b0);
        tick();
        check_eq("lat_cyc2_valid2", out_valid2, 1'b1);
        check_eq("lat_cyc2_result2", result2, 8'h03);
        check_eq("lat_cyc2_flags2", flags2, 4'b0000);
        check_eq("lat_cyc2_valid3", out_valid3, 1'b0);
        tick();
        check_eq("lat_cyc3_valid3", out_valid3, 1'b1);
        check_eq("lat_cyc3_result3", result3, 8'h03);
        check_eq("lat_cyc3_valid2", out_valid2, 1'b0);
        repeat (2) tick();

        // Back-to-back streaming through the 2-stage pipe.
        drive(ALU_ADD, 8'h7F, 8'h01);
        in_valid = 1'b1;
        tick();
        drive(ALU_SUB, 8'h00, 8'h01);
        tick();
        check_eq("stream_add_valid", out_valid2, 1'b1);
        check_eq("stream_add_res",   result2,    8'h80);
        check_eq("stream_add_flg",   flags2,     4'b1010);
        drive(ALU_AND, 8'hF0, 8'h3C);
        tick();
        in_valid = 1'b0;
        check_eq("stream_sub_valid", out_valid2, 1'b1);
        check_eq("stream_sub_res",   result2,    8'hFF);
        check_eq("stream_sub_flg",   flags2,     4'b0010);
        tick();
        check_eq("stream_and_valid", out_valid2, 1'b1);
        check_eq("stream_and_res",   result2,    8'h30);
        check_eq("stream_and_flg",   flags2,     4'b0000);
        repeat (3) tick();

        // Opcode and flag corner vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vop[i], va[i], vb[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            check_eq($sformatf("vec%0d_valid", i), out_valid2, 1'b1);
            check_eq($sformatf("vec%0d_res", i),   result2,    vr[i]);
            check_eq($sformatf("vec%0d_flg", i),   flags2,     vf[i]);
        end
        repeat (4) tick();

        // Backpressure on the 3-stage pipe: fill with out_ready low.
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (idx < 5) begin
                a_v = 8'h10 + idx[7:0];
                drive(ALU_ADD, a_v, 8'h01);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready3;
            @(posedge clk);
            if (acc) idx++;
            #1;
        end
        check_eq("bp_accepted",   idx,        3);
        check_eq("bp_in_ready",   in_ready3,  1'b0);
        check_eq("bp_out_valid",  out_valid3, 1'b1);
        check_eq("bp_head_res",   result3,    8'h11);
        repeat (2) tick();
        check_eq("bp_stable_res", result3,    8'h11);
        check_eq("bp_stable_flg", flags3,     4'b0000);

        // Release: head leaves and a new bundle enters on the same edge.
        out_ready = 1'b1;
        #1;
        check_eq("bp_refill_ready", in_ready3, 1'b1);
        outcnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (out_valid3) begin
                e_v = 8'h11 + outcnt[7:0];
                check_eq($sformatf("bp_order%0d", outcnt), result3, e_v);
                outcnt++;
            end
            if (idx < 5) begin
                a_v = 8'h10 + idx[7:0];
                drive(ALU_ADD, a_v, 8'h01);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready3;
            @(posedge clk);
            if (acc) idx++;
            #1;
            if (cyc == 0) check_eq("bp_same_cycle_accept", idx, 4);
        end
        check_eq("bp_out_count", outcnt, 5);
        check_eq("bp_in_count",  idx,    5);
        repeat (3) tick();

        // Mid-flight asynchronous reset with two bundles held in the 2-stage pipe.
        out_ready = 1'b0;
        drive(ALU_ADD, 8'h40, 8'h01);
        in_valid = 1'b1;
        tick();
        drive(ALU_ADD, 8'h50, 8'h01);
        tick();
        in_valid = 1'b0;
        check_eq("mf_held_valid", out_valid2, 1'b1);
        check_eq("mf_held_res",   result2,    8'h41);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("mf_async_valid2", out_valid2, 1'b0);
        check_eq("mf_async_res2",   result2,    8'h00);
        check_eq("mf_async_valid3", out_valid3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("mf_rel_ready", in_ready2, 1'b1);
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            check_eq($sformatf("mf_none2_c%0d", cyc), out_valid2, 1'b0);
            check_eq($sformatf("mf_none3_c%0d", cyc), out_valid3, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle registered N-bit ALU.
- Accepts one operation per cycle through a valid/ready input handshake and delivers the result and status flags after a configurable number of register stages.
- The output side uses a valid/ready handshake with full backpressure.
- Sits between an instruction/operand source and any consumer that may stall.

Parameters:
- N, 8, operand/result width in bits; legal range 2..64.
- STAGES, 2, number of register stages from input handshake to output; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op bundle valid.
- in_ready  output  1  block can accept the bundle this cycle.
- operand1  input  N  first operand (A).
- operand2  input  N  second operand (B); for shifts, the low clog2(N) bits are the shift amount.
- operation  input  3  opcode, alu_pkg::alu_op_e.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the bundle this cycle.
- result  output  N  ALU result.
- flags  output  4  {overflow, carry, negative, zero}.

Behaviour:
- Reset: clk is the single clock; reset_n is asynchronous and active-low.
  - While reset_n=0, all stage valid bits are 0 and out_valid=0.
  - result, flags and all stage data registers are 0.
  - in_ready=1 as soon as reset_n deasserts.
- Reset mid-operation discards all in-flight bundles; nothing is replayed.
- Transfers:
  - An input transfer occurs when in_valid&&in_ready.
  - An output transfer occurs when out_valid&&out_ready.
- Datapath:
  - Compute is combinational on the input bundle, ahead of stage 1.
  - Stages 2..STAGES carry {result, flags} unchanged.
  - Latency is exactly STAGES cycles from input transfer to out_valid with no stalls (STAGES=1 matches the old registered ALU timing).
- Pipeline control, per stage k with valid bit v[k]:
  - ready[k] = !v[k] || ready[k+1].
  - ready[STAGES+1] = out_ready.
  - in_ready = ready[1].
  - A stage loads when ready[k] is 1; its valid becomes the upstream valid.
- Throughput: one bundle per cycle when out_ready is held 1.
- Backpressure:
  - With out_ready=0 the pipe fills, holding at most STAGES bundles, then in_ready drops combinationally.
  - No bundle is dropped or duplicated.
  - result/flags stay stable while out_valid=1 and out_ready=0.
- Simultaneous full pipe, out_ready=1 and in_valid=1: the input is accepted in the same cycle (bubble-free).
- Opcodes (unsigned arithmetic mod 2^N):
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A << B[clog2(N)-1:0], zero fill.
  - 110 SHR: logical right shift by the same amount, zero fill.
  - 111 PASSB: B.
- Flags:
  - zero = (result==0), all ops.
  - negative = result[N-1], all ops.
  - carry: ADD gives the carry-out of the N-bit sum; SUB gives bit N of A+~B+1 (1 = no borrow); 0 for all other ops.
  - overflow: signed two's-complement overflow for ADD/SUB; 0 otherwise.
- Shift amount of 0 gives result A, carry 0.
- No X propagation: data registers load only on stage enable; an unused opcode cannot occur (the 3-bit opcode space is full).

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASSB}.
  - localparams for the flag bit indices FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3.
- Sub-module alu_exec #(N): purely combinational; computes result and flags from operand1, operand2 and operation.
- alu_pipe holds the generate loop of STAGES handshake registers.

Test Plan:
- Reset with in_valid=1 held: reset_n=0 → out_valid=0, result=0, flags=0; after release, in_ready=1 and the first bundle emerges exactly STAGES cycles after acceptance.
- N=8, STAGES=2, out_ready=1: stream ADD 8'h7F+8'h01, SUB 8'h00-8'h01, AND 8'hF0&8'h3C on consecutive cycles → back-to-back outputs:
  - 8'h80, flags {V=1, C=0, N=1, Z=0}.
  - 8'hFF, flags {V=0, C=0, N=1, Z=0}.
  - 8'h30, flags {V=0, C=0, N=0, Z=0}.
- N=8: ADD 8'hFF+8'h01 → 8'h00, flags {V=0, C=1, N=0, Z=1}; SUB 8'h05-8'h05 → 8'h00, C=1, Z=1.
- Shifts, N=8: SHL 8'h81 by operand2=8'hF9 (amount 1) → 8'h02; SHR 8'h80 by 3 → 8'h10; shift by 0 → A unchanged.
- Backpressure, STAGES=3: hold out_ready=0 while driving 5 bundles → exactly 3 accepted, then in_ready=0 and output stable; raise out_ready → all bundles delivered in order, and an input is accepted in the same cycle the head leaves.
- Mid-flight reset: 2 bundles in pipe, pulse reset_n low between clock edges → out_valid falls asynchronously; neither bundle ever appears after release.
